ad1_sample_accum: RTL and testbench
===================================

# ad1_sample_accum

Downstream consumer of the PmodAD1 SPI controller. Detects each new conversion pair on the controller's `drdy` and `dout0`/`dout1` outputs and averages 2^AVG_LOG2 consecutive samples per channel. Pushes each averaged pair into a small FIFO, which is drained through an AXI4-Stream master port toward the IP's bus interface or DMA.

## Interface
Parameters:
- `AVG_LOG2`, 2: log2 of samples averaged per output word; legal range 0..4 (0 gives pass-through).
- `FIFO_DEPTH_LOG2`, 4: log2 of FIFO depth in words; legal range 1..8.
- `PACKET_LEN`, 16: words per stream packet; used only when `AD1_SAMPLE_ACCUM_TLAST_EN` is defined.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  accumulate enable; while low, edges are ignored and the accumulator is cleared.
- `drdy`  in  1  data-ready level from the SPI controller; held high for several hundred cycles per conversion.
- `din0`  in  16  channel 0 word; sample = `din0[11:0]`, bits [15:12] ignored.
- `din1`  in  16  channel 1 word; sample = `din1[11:0]`.
- `m_axis_tdata`  out  32  {4'b0, avg1[11:0], 4'b0, avg0[11:0]}.
- `m_axis_tvalid`  out  1  FIFO not empty.
- `m_axis_tready`  in  1  sink ready.
- `m_axis_tlast`  out  1  packet boundary; present only with the macro defined.
- `fifo_count`  out  FIFO_DEPTH_LOG2+1  current occupancy.
- `overflow`  out  1  sticky: an averaged word was dropped.
- `clr_ovf`  in  1  synchronous clear of `overflow`.

## Operation
- Edge detect: `drdy_q` is a registered copy of `drdy`. `new_smp = drdy & ~drdy_q & en`.
- Two 16-bit accumulators (12 + 4 bits) and a 4-bit sample counter `scnt`.
- FSM states:
  - S_IDLE: entered on reset, and from any state whenever `en` is low. Clears the accumulators, `scnt` and `pend`. Moves to S_ACC when `en` is high.
  - S_ACC: on `new_smp` (or `pend`), adds `din0[11:0]`/`din1[11:0]` to the accumulators and clears `pend`. If `scnt == 2^AVG_LOG2-1`, registers `sum >> AVG_LOG2` into the result registers, clears the accumulators and `scnt`, and moves to S_PUSH. Otherwise increments `scnt`.
  - S_PUSH: one cycle. Writes the result word into the FIFO, then returns to S_ACC. A `new_smp` arriving in this cycle sets `pend`, and the sample is consumed on the next S_ACC cycle. `din` is stable across the whole `drdy` high window, so a one-cycle delay is safe.
- Averaging is truncating (floor); the shifted result always fits in 12 bits.
- FIFO:
  - Circular buffer of 2^FIFO_DEPTH_LOG2 words with read and write pointers and an occupancy counter.
  - `tdata` reads `mem[rd_ptr]` combinationally.
  - Pop occurs when `tvalid & tready`.
  - Push is accepted when not full, or when a pop happens in the same cycle.
  - Push while full with no pop: the word is dropped, the FIFO is unchanged, and `overflow` is set.
  - Pointers wrap modulo depth.
  - Simultaneous push and pop leaves `fifo_count` unchanged.
- `overflow`: a set event takes priority over `clr_ovf` in the same cycle.
- Reset (async assert, any time): all outputs go to 0 (`tvalid`=0, `tdata`=0, `fifo_count`=0, `overflow`=0, `tlast`=0). FSM enters S_IDLE, pointers, accumulators and `drdy_q` clear, and in-flight partial averages are discarded. FIFO RAM contents are not reset.

## Timing
- Final sample: `new_smp` sampled at edge k → S_PUSH during cycle k..k+1 → FIFO write at edge k+1 → `tvalid` high after edge k+1. Total latency is 2 edges.
- `tvalid` never depends combinationally on `tready`. `tdata`/`tvalid` hold stable until accepted.
- A `drdy` that is already high when `en` rises produces no edge; the first sample is taken at the next rising edge.
- Maximum sustained input rate: one `new_smp` per 2 cycles.

## Configuration
- `AD1_SAMPLE_ACCUM_TLAST_EN` defined:
  - `m_axis_tlast` exists.
  - A popped-word counter asserts `tlast` on every PACKET_LEN-th accepted word.
  - The counter wraps to 0 after that word and resets to 0 on `rst_n`.
- Undefined: the port and counter are absent; the stream is unframed.

## Structure
- Shared package `ad1_pkg`:
  - State encoding (S_IDLE, S_ACC, S_PUSH).
  - Sample width (12).
  - Packed word layout: field offsets 0 and 16, pad 4 bits.
- One sub-module, `ad1_sync_fifo` (width, depth parameters; push/pop/full/empty/count). The top level holds the edge detect, FSM, accumulators and overflow flag.

## Test plan
- Reset mid-accumulation (AVG_LOG2=2): 3 samples accepted, then `rst_n` pulsed low → `fifo_count`=0, `tvalid`=0. The next 4 samples yield exactly one word.
- Average (AVG_LOG2=2): ch0 = 100, 101, 102, 104 with ch1=4095 for all four, `tready`=1 → one word 0x0FFF_0065 (avg0 = 407>>2 = 101), with `tvalid` asserting 2 edges after the 4th `drdy` rise.
- Upper bits ignored (AVG_LOG2=0): `din0`=0xF123 → `tdata[15:0]`=0x0123.
- Overflow (FIFO_DEPTH_LOG2=2, `tready`=0): 5 averaged words → `fifo_count`=4 and `overflow`=1. Draining returns the first 4 words in order. `clr_ovf` then clears the flag.
- Full with simultaneous pop: FIFO full, push coincides with `tready`=1 → push accepted, `fifo_count` stays at 4, `overflow` stays 0.
- TLAST (macro defined, PACKET_LEN=3, 7 words streamed with `tready` toggling 1/0) → `tlast` high on accepted words 3 and 6 only.

Source files
------------

// File: rtl/ad1_pkg.sv
// Shared state encoding, sample width and output word layout for the
// PmodAD1 sample accumulator.
package ad1_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_PUSH = 2'd2
    } state_t;

    localparam int SMP_W   = 12;
    localparam int PAD_W   = 4;
    localparam int ACC_W   = SMP_W + 4;
    localparam int WORD_W  = 32;
    localparam int CH0_OFS = 0;
    localparam int CH1_OFS = CH0_OFS + SMP_W + PAD_W;

    // Each 12-bit average sits in the low bits of its 16-bit half.
    function automatic logic [WORD_W-1:0] pack_word(input logic [SMP_W-1:0] avg0,
                                                    input logic [SMP_W-1:0] avg1);
        logic [WORD_W-1:0] w;
        w = '0;
        w[CH0_OFS +: SMP_W] = avg0;
        w[CH1_OFS +: SMP_W] = avg1;
        return w;
    endfunction

endpackage

// File: rtl/ad1_sync_fifo.sv
// Synchronous FIFO: circular buffer with occupancy counter. Read data comes
// combinationally from the head slot and reads as zero while empty.
module ad1_sync_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic                pop,
    input  logic [WIDTH-1:0]    wdata,
    output logic [WIDTH-1:0]    rdata,
    output logic                full,
    output logic                empty,
    output logic [DEPTH_LOG2:0] count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == (DEPTH_LOG2+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // NOTE: the RAM is deliberately left out of reset; only pointers and count
    // define what is valid, and a reset-free array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ad1_sample_accum.sv
// Averages 2^AVG_LOG2 PmodAD1 conversion pairs and streams them out via a FIFO.
// Define AD1_SAMPLE_ACCUM_TLAST_EN to add m_axis_tlast every PACKET_LEN words.
module ad1_sample_accum
    import ad1_pkg::*;
#(
    parameter int AVG_LOG2        = 2,
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int PACKET_LEN      = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     drdy,
    input  logic [15:0]              din0,
    input  logic [15:0]              din1,
    output logic [31:0]              m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
`ifdef AD1_SAMPLE_ACCUM_TLAST_EN
    output logic                     m_axis_tlast,
`endif
    output logic [FIFO_DEPTH_LOG2:0] fifo_count,
    output logic                     overflow,
    input  logic                     clr_ovf
);

    localparam logic [3:0] SCNT_LAST = 4'((1 << AVG_LOG2) - 1);

    state_t           state;
    state_t           state_nxt;
    logic             drdy_q;
    logic             new_smp;
    logic [ACC_W-1:0] acc0, acc1;
    logic [ACC_W-1:0] sum0, sum1;
    logic [3:0]       scnt;
    logic             pend;
    logic [SMP_W-1:0] res0, res1;
    logic             clr_acc, add_smp, last_smp, push, set_pend;
    logic             pop, full, empty, drop;
    logic             unused_hi;

    assign new_smp   = drdy & ~drdy_q & en;
    assign sum0      = acc0 + ACC_W'(din0[SMP_W-1:0]);
    assign sum1      = acc1 + ACC_W'(din1[SMP_W-1:0]);
    assign unused_hi = ^{din0[15:SMP_W], din1[15:SMP_W]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drdy_q <= 1'b0;
            state  <= S_IDLE;
        end else begin
            drdy_q <= drdy;
            state  <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        clr_acc   = 1'b0;
        add_smp   = 1'b0;
        last_smp  = 1'b0;
        push      = 1'b0;
        set_pend  = 1'b0;
        if (!en) begin
            state_nxt = S_IDLE;
            clr_acc   = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    clr_acc   = 1'b1;
                    state_nxt = S_ACC;
                end
                S_ACC: begin
                    if (new_smp || pend) begin
                        add_smp = 1'b1;
                        if (scnt == SCNT_LAST) begin
                            last_smp  = 1'b1;
                            state_nxt = S_PUSH;
                        end
                    end
                end
                S_PUSH: begin
                    push      = 1'b1;
                    set_pend  = new_smp;
                    state_nxt = S_ACC;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // An edge seen during S_PUSH is parked in pend; din holds through drdy high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc0 <= '0;
            acc1 <= '0;
            scnt <= '0;
            pend <= 1'b0;
            res0 <= '0;
            res1 <= '0;
        end else if (clr_acc) begin
            acc0 <= '0;
            acc1 <= '0;
            scnt <= '0;
            pend <= 1'b0;
        end else if (add_smp) begin
            pend <= 1'b0;
            if (last_smp) begin
                res0 <= SMP_W'(sum0 >> AVG_LOG2);
                res1 <= SMP_W'(sum1 >> AVG_LOG2);
                acc0 <= '0;
                acc1 <= '0;
                scnt <= '0;
            end else begin
                acc0 <= sum0;
                acc1 <= sum1;
                scnt <= scnt + 1'b1;
            end
        end else if (set_pend) begin
            pend <= 1'b1;
        end
    end

    assign m_axis_tvalid = ~empty;
    assign pop           = m_axis_tvalid & m_axis_tready;
    assign drop          = push & full & ~pop;

    // A drop in the same cycle as clr_ovf must stay visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       overflow <= 1'b0;
        else if (drop)    overflow <= 1'b1;
        else if (clr_ovf) overflow <= 1'b0;
    end

    ad1_sync_fifo #(
        .WIDTH      (WORD_W),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (pack_word(res0, res1)),
        .rdata (m_axis_tdata),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

`ifdef AD1_SAMPLE_ACCUM_TLAST_EN
    localparam int              PKT_W    = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1;
    localparam logic [PKT_W-1:0] PKT_LAST = PKT_W'(PACKET_LEN - 1);

    logic [PKT_W-1:0] pkt_cnt;

    assign m_axis_tlast = m_axis_tvalid & (pkt_cnt == PKT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   pkt_cnt <= '0;
        else if (pop) pkt_cnt <= (pkt_cnt == PKT_LAST) ? '0 : pkt_cnt + 1'b1;
    end
`else
    logic unused_pkt;
    assign unused_pkt = (PACKET_LEN != 0);
`endif

endmodule

// File: tb/tb_ad1_sample_accum.sv
// Directed bench for ad1_sample_accum (AVG_LOG2=2, FIFO depth 4, PACKET_LEN=3).
// Define AD1_SAMPLE_ACCUM_TLAST_EN to also exercise the tlast framing.
module tb_ad1_sample_accum;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        drdy;
    logic [15:0] din0, din1;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [2:0]  fifo_count;
    logic        overflow;
    logic        clr_ovf;
`ifdef AD1_SAMPLE_ACCUM_TLAST_EN
    logic        m_axis_tlast;
`endif

    int vectors     = 0;
    int miscompares = 0;

    ad1_sample_accum #(
        .AVG_LOG2        (2),
        .FIFO_DEPTH_LOG2 (2),
        .PACKET_LEN      (3)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .drdy          (drdy),
        .din0          (din0),
        .din1          (din1),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
`ifdef AD1_SAMPLE_ACCUM_TLAST_EN
        .m_axis_tlast  (m_axis_tlast),
`endif
        .fifo_count    (fifo_count),
        .overflow      (overflow),
        .clr_ovf       (clr_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // One conversion: drdy high for 2 cycles, low for 2; sample taken at the first edge.
    task automatic send_sample(input logic [15:0] d0, input logic [15:0] d1);
        din0 = d0;
        din1 = d1;
        drdy = 1'b1;
        step();
        step();
        drdy = 1'b0;
        step();
        step();
    endtask

    task automatic send_word(input logic [15:0] d0, input logic [15:0] d1);
        for (int i = 0; i < 4; i++) send_sample(d0, d1);
    endtask

    logic [31:0] ovf_exp  [4] = '{32'h00C8_0001, 32'h00C9_0011, 32'h00CA_0021, 32'h00CB_0031};
    logic [31:0] full_exp [4] = '{32'h0201_0101, 32'h0202_0102, 32'h0203_0103, 32'h0204_0104};
`ifdef AD1_SAMPLE_ACCUM_TLAST_EN
    logic        tl_exp   [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
`endif

    initial begin
        rst_n = 1'b0; en = 1'b0; drdy = 1'b0; din0 = '0; din1 = '0;
        m_axis_tready = 1'b0; clr_ovf = 1'b0;
        step();
        step();
        check("reset_tvalid", 32'(m_axis_tvalid), 32'h0);
        check("reset_tdata",  m_axis_tdata,       32'h0);
        check("reset_count",  32'(fifo_count),    32'h0);
        check("reset_ovf",    32'(overflow),      32'h0);
`ifdef AD1_SAMPLE_ACCUM_TLAST_EN
        check("reset_tlast",  32'(m_axis_tlast),  32'h0);
`endif
        rst_n = 1'b1;
        en    = 1'b1;
        step();
        step();

        // Average of 100,101,102,104 -> 101; ch1 constant 4095; latency 2 edges.
        m_axis_tready = 1'b1;
        send_sample(16'd100, 16'd4095);
        send_sample(16'd101, 16'd4095);
        send_sample(16'd102, 16'd4095);
        din0 = 16'd104;
        drdy = 1'b1;
        step();
        check("avg_tvalid_edge1", 32'(m_axis_tvalid), 32'h0);
        step();
        check("avg_tvalid_edge2", 32'(m_axis_tvalid), 32'h1);
        check("avg_tdata",        m_axis_tdata,       32'h0FFF_0065);
        check("avg_count",        32'(fifo_count),    32'h1);
        drdy = 1'b0;
        step();
        check("avg_popped",       32'(fifo_count),    32'h0);
        m_axis_tready = 1'b0;
        step();

        // Upper nibble of each channel word must be ignored.
        send_word(16'hF123, 16'hA456);
        check("upper_bits_tdata", m_axis_tdata,       32'h0456_0123);
        check("upper_bits_count", 32'(fifo_count),    32'h1);

        // Reset mid-accumulation discards the partial sum and the queued word.
        send_sample(16'd500, 16'd500);
        send_sample(16'd500, 16'd500);
        send_sample(16'd500, 16'd500);
        rst_n = 1'b0;
        #2;
        check("midrst_count",  32'(fifo_count),    32'h0);
        check("midrst_tvalid", 32'(m_axis_tvalid), 32'h0);
        step();
        rst_n = 1'b1;
        step();
        send_sample(16'd8,  16'd1);
        send_sample(16'd8,  16'd2);
        send_sample(16'd8,  16'd3);
        check("midrst_no_early_word", 32'(fifo_count), 32'h0);
        send_sample(16'd12, 16'd4);
        check("midrst_count_after", 32'(fifo_count), 32'h1);
        check("midrst_tdata",       m_axis_tdata,    32'h0002_0009);
        m_axis_tready = 1'b1;
        step();
        m_axis_tready = 1'b0;
        check("midrst_drained", 32'(fifo_count), 32'h0);

        // Overflow: five words into a four-deep FIFO with the sink stalled.
        for (int i = 0; i < 5; i++) begin
            send_word(16'(16 * i + 1), 16'(200 + i));
            if (i == 3) begin
                check("ovf_full_count",  32'(fifo_count), 32'h4);
                check("ovf_not_yet_set", 32'(overflow),   32'h0);
            end
        end
        check("ovf_count", 32'(fifo_count), 32'h4);
        check("ovf_flag",  32'(overflow),   32'h1);
        m_axis_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ovf_drain%0d", i), m_axis_tdata, ovf_exp[i]);
            step();
        end
        m_axis_tready = 1'b0;
        check("ovf_drained_tvalid", 32'(m_axis_tvalid), 32'h0);
        check("ovf_sticky",         32'(overflow),      32'h1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'h0);

        // Full FIFO: the push coincides with a pop and must be accepted.
        for (int i = 0; i < 4; i++) send_word(16'(16'h100 + i), 16'(16'h200 + i));
        check("fullpop_pre_count", 32'(fifo_count), 32'h4);
        for (int i = 0; i < 3; i++) send_sample(16'h104, 16'h204);
        din0 = 16'h104;
        din1 = 16'h204;
        drdy = 1'b1;
        step();
        m_axis_tready = 1'b1;
        step();
        m_axis_tready = 1'b0;
        check("fullpop_count", 32'(fifo_count), 32'h4);
        check("fullpop_ovf",   32'(overflow),   32'h0);
        drdy = 1'b0;
        step();
        m_axis_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("fullpop_drain%0d", i), m_axis_tdata, full_exp[i]);
            step();
        end
        m_axis_tready = 1'b0;
        check("fullpop_empty", 32'(fifo_count), 32'h0);

`ifdef AD1_SAMPLE_ACCUM_TLAST_EN
        // Fresh packet count, then 7 words accepted with tready toggling.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        begin
            int n = 0;
            for (int blk = 0; blk < 2; blk++) begin
                int words = (blk == 0) ? 4 : 3;
                for (int i = 0; i < words; i++) send_word(16'(i + 1), 16'(blk));
                for (int j = 0; j < 2 * words; j++) begin
                    m_axis_tready = (j % 2 == 0);
                    if (m_axis_tready) begin
                        check($sformatf("tlast_valid%0d", n), 32'(m_axis_tvalid), 32'h1);
                        check($sformatf("tlast_word%0d", n + 1), 32'(m_axis_tlast), 32'(tl_exp[n]));
                        n++;
                    end
                    step();
                end
                m_axis_tready = 1'b0;
            end
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
